calc_ctrl: RTL

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/calc_btn_cond.sv | 71 +++++++
 rtl/calc_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator controller.
//   - op encoding (op_e), FSM state type (state_e), display mode (mode_e)
//   - result width (15), operand width (7), button index constants
//   - helpers: BCD digit pair to binary, modulo-10 digit increment
package calc_pkg;

  localparam int unsigned RES_W   = 15;
  localparam int unsigned OPND_W  = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NUM_BTN = 9;

  localparam int unsigned BTN_D1   = 0;
  localparam int unsigned BTN_D2   = 1;
  localparam int unsigned BTN_D3   = 2;
  localparam int unsigned BTN_D4   = 3;
  localparam int unsigned BTN_ADD  = 4;
  localparam int unsigned BTN_SUB  = 5;
  localparam int unsigned BTN_MUL  = 6;
  localparam int unsigned BTN_DIV  = 7;
  localparam int unsigned BTN_DISP = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  typedef enum logic {
    MODE_OPERAND = 1'b0,
    MODE_RESULT  = 1'b1
  } mode_e;

  // Two BCD digits (tens, units) to a binary operand 0..99.
  function automatic logic [OPND_W-1:0] bcd_pair(input logic [DIGIT_W-1:0] hi,
                                                 input logic [DIGIT_W-1:0] lo);
    return OPND_W'(hi) * OPND_W'(10) + OPND_W'(lo);
  endfunction

  // Modulo-10 increment: 9 wraps to 0.
  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/calc_btn_cond.sv
// calc_btn_cond: conditions one raw push button into a single-cycle pulse.
//   2-FF synchronizer, optional debounce, rising-edge detect; pulse is registered.
//   Macro CALC_CTRL_DEBOUNCE_EN: when defined, a level change is accepted only
//   after DB_CYCLES consecutive identical synchronized samples.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset
//   btn   : raw (asynchronous) button level
//   pulse : one-cycle pulse per accepted press
module calc_btn_cond #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef CALC_CTRL_DEBOUNCE_EN
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          stable;
  logic [CW-1:0] cnt;

  // cnt counts how many samples in a row have differed from the accepted
  // level; the new level is adopted on the DB_CYCLES-th such sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
        pulse  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= s2;
      pulse <= s2 & ~prev;
    end
  end
`endif

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: four-digit BCD calculator front end driving an external ALU.
//   Buttons edit two 2-digit operands, request add/sub/mul/div, toggle the
//   display between operands (A*100+B) and the last result.
//   Macro CALC_CTRL_DEBOUNCE_EN enables per-button debounce in calc_btn_cond.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   btn[8:0]                : [3:0] digit increments, [4..7] add/sub/mul/div, [8] display toggle
//   alu_start/op/a/b        : one-cycle request with latched operation and operands
//   alu_done, alu_result    : completion pulse and signed result
//   digit1..digit4          : BCD digits
//   disp_value, disp_err    : displayed signed value, error flag
//   busy                    : operation in progress (ISSUE or WAIT)
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BTN-1:0]       btn,
  output logic                     alu_start,
  output logic [1:0]               alu_op,
  output logic [OPND_W-1:0]        alu_a,
  output logic [OPND_W-1:0]        alu_b,
  input  logic                     alu_done,
  input  logic signed [RES_W-1:0]  alu_result,
  output logic [DIGIT_W-1:0]       digit1,
  output logic [DIGIT_W-1:0]       digit2,
  output logic [DIGIT_W-1:0]       digit3,
  output logic [DIGIT_W-1:0]       digit4,
  output logic signed [RES_W-1:0]  disp_value,
  output logic                     disp_err,
  output logic                     busy
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [NUM_BTN-1:0] pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    calc_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .pulse (pulse[i])
    );
  end

  state_e                     state_q, state_n;
  mode_e                      mode_q, mode_n;
  op_e                        op_q, op_n;
  logic [DIGIT_W-1:0]         dig_q [4];
  logic [DIGIT_W-1:0]         dig_n [4];
  logic [OPND_W-1:0]          a_q, a_n, b_q, b_n;
  logic signed [RES_W-1:0]    result_q, result_n;
  logic signed [RES_W-1:0]    disp_q, disp_n;
  logic                       err_q, err_n;
  logic                       start_q, start_n;
  logic                       busy_q, busy_n;
  logic [TW-1:0]              tcnt_q, tcnt_n;

  logic [OPND_W-1:0]          opa, opb, opa_n, opb_n;
  logic [RES_W-1:0]           opnd_disp;
  logic                       op_req;
  op_e                        op_sel;

  always_comb begin
    opa    = bcd_pair(dig_q[0], dig_q[1]);
    opb    = bcd_pair(dig_q[2], dig_q[3]);
    op_req = pulse[BTN_ADD] | pulse[BTN_SUB] | pulse[BTN_MUL] | pulse[BTN_DIV];
    if (pulse[BTN_ADD])      op_sel = OP_ADD;
    else if (pulse[BTN_SUB]) op_sel = OP_SUB;
    else if (pulse[BTN_MUL]) op_sel = OP_MUL;
    else                     op_sel = OP_DIV;
  end

  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    result_n = result_q;
    err_n    = err_q;
    start_n  = 1'b0;
    tcnt_n   = tcnt_q;
    for (int unsigned i = 0; i < 4; i++) dig_n[i] = dig_q[i];

    case (state_q)
      ST_IDLE, ST_ERR: begin
        tcnt_n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
          if (pulse[BTN_D1 + i]) dig_n[i] = next_digit(dig_q[i]);
        end
        if (pulse[BTN_DISP]) begin
          mode_n = (mode_q == MODE_OPERAND) ? MODE_RESULT : MODE_OPERAND;
        end
        if (op_req) begin
          op_n = op_sel;
          a_n  = opa;
          b_n  = opb;
          if (op_sel == OP_DIV && opb == '0) begin
            state_n = ST_ERR;
            err_n   = 1'b1;
          end else begin
            state_n = ST_ISSUE;
            start_n = 1'b1;
            err_n   = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
        tcnt_n  = tcnt_q + 1'b1;
      end
      ST_WAIT: begin
        // tcnt starts counting in ISSUE so the limit lands TIMEOUT cycles
        // after alu_start rose.
        if (alu_done) begin
          state_n  = ST_IDLE;
          result_n = alu_result;
          mode_n   = MODE_RESULT;
          err_n    = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_n = ST_ERR;
          err_n   = 1'b1;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Display is computed from next-state values so the registered output
    // reflects digit/mode/result changes on the same edge.
    opa_n     = bcd_pair(dig_n[0], dig_n[1]);
    opb_n     = bcd_pair(dig_n[2], dig_n[3]);
    opnd_disp = RES_W'(opa_n) * RES_W'(100) + RES_W'(opb_n);
    disp_n    = (mode_n == MODE_OPERAND) ? $signed(opnd_disp) : result_n;
    busy_n    = (state_n == ST_ISSUE) || (state_n == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_OPERAND;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      disp_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      tcnt_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) dig_q[i] <= '0;
    end else begin
      state_q  <= state_n;
      mode_q   <= mode_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      result_q <= result_n;
      disp_q   <= disp_n;
      err_q    <= err_n;
      start_q  <= start_n;
      busy_q   <= busy_n;
      tcnt_q   <= tcnt_n;
      for (int unsigned i = 0; i < 4; i++) dig_q[i] <= dig_n[i];
    end
  end

  assign alu_start  = start_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign digit1     = dig_q[0];
  assign digit2     = dig_q[1];
  assign digit3     = dig_q[2];
  assign digit4     = dig_q[3];
  assign disp_value = disp_q;
  assign disp_err   = err_q;
  assign busy       = busy_q;

endmodule
